// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with an input FIFO, optional parity and one or two stop bits.
// Line settings are captured per frame, so a frame is unaffected by input changes once it starts.
module uart_tx_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Par_EN,
  input  logic                  Par_TYP,
  input  logic                  Stop_Two,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  Tx_out,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  overflow_q;

  state_t                state_q;
  logic                  tx_q, busy_q;
  logic [PRESCALE_W-1:0] cnt_q, presc_q;
  logic [3:0]            bit_idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_q, par_en_q, stop2_q;

  logic                  push, pop, last_stop;
  logic [PRESCALE_W-1:0] presc_eff;
  logic [DATA_WIDTH-1:0] front;

  always_comb begin
    fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
    push      = Data_Valid && !fifo_full;
    presc_eff = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
    front     = mem_q[rd_ptr_q];
    // Final stop-bit boundary: the only point besides IDLE where the next word may be taken.
    last_stop = (state_q == STOP) && (cnt_q == '0) && !(stop2_q && (bit_idx_q == '0));
    pop       = (count_q != '0) && ((state_q == IDLE) || last_stop);
  end

  assign Tx_out   = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= P_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q <= Data_Valid && fifo_full;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      presc_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      state_q   <= START;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
      cnt_q     <= presc_eff - PRESCALE_W'(1);
      presc_q   <= presc_eff;
      bit_idx_q <= '0;
      data_q    <= front;
      par_q     <= (^front) ^ Par_TYP;
      par_en_q  <= Par_EN;
      stop2_q   <= Stop_Two;
    end else if (state_q != IDLE) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - PRESCALE_W'(1);
      end else begin
        cnt_q <= presc_q - PRESCALE_W'(1);
        case (state_q)
          START: begin
            state_q   <= DATA;
            tx_q      <= data_q[0];
            bit_idx_q <= '0;
          end
          DATA: begin
            if (bit_idx_q == 4'(DATA_WIDTH - 1)) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              // data_q[0] always mirrors the bit on the line while in DATA
              bit_idx_q <= bit_idx_q + 4'd1;
              data_q    <= data_q >> 1;
              tx_q      <= data_q[1];
            end
          end
          PARITY: begin
            state_q   <= STOP;
            tx_q      <= 1'b1;
            bit_idx_q <= '0;
          end
          STOP: begin
            tx_q <= 1'b1;
            if (stop2_q && (bit_idx_q == '0)) begin
              bit_idx_q <= 4'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame bit patterns, timing, FIFO back-to-back/overflow, reset abort.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  P_DATA = '0;
  logic        Data_Valid = 1'b0;
  logic        Par_EN = 1'b0;
  logic        Par_TYP = 1'b0;
  logic        Stop_Two = 1'b0;
  logic [15:0] Prescale = 16'd1;
  logic        Tx_out, busy, fifo_full, overflow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  uart_tx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Par_EN(Par_EN), .Par_TYP(Par_TYP), .Stop_Two(Stop_Two), .Prescale(Prescale),
    .Tx_out(Tx_out), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic write_word(input logic [7:0] d);
    @(negedge clk);
    P_DATA = d;
    Data_Valid = 1'b1;
    @(posedge clk); #1;
    Data_Valid = 1'b0;
  endtask

  // Writes 1..n on consecutive edges, recording fifo_full/overflow just after each edge.
  task automatic write_burst(input int unsigned n, output logic [7:0] full_seen,
                             output logic [7:0] ov_seen);
    full_seen = '0;
    ov_seen   = '0;
    @(negedge clk);
    Data_Valid = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      P_DATA = 8'(k + 1);
      @(posedge clk); #1;
      full_seen[k] = fifo_full;
      ov_seen[k]   = overflow;
    end
    Data_Valid = 1'b0;
  endtask

  // Records Tx_out each cycle while busy; ncyc=0 if busy never rises within 20 cycles.
  task automatic capture(output logic [127:0] line, output int unsigned ncyc);
    int unsigned w;
    line = '1;
    ncyc = 0;
    w    = 0;
    @(posedge clk); #1;
    while (!busy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    while (busy && ncyc < 128) begin
      line[ncyc] = Tx_out;
      ncyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (Tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Tx_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_parity_odd;
    logic [127:0] line;
    int unsigned  n;
    Par_EN = 1'b1; Par_TYP = 1'b1; Stop_Two = 1'b0; Prescale = 16'd1;
    write_word(8'hDA);
    capture(line, n);
    checks++; if (n != 11) begin errors++; $display("FAIL odd_busy_len: got %0d want 11", n); end
    checks++; if (line[10:0] !== 11'b10110110100) begin
      errors++; $display("FAIL odd_frame: got %b want %b", line[10:0], 11'b10110110100);
    end
    checks++; if (Tx_out !== 1'b1) begin errors++; $display("FAIL odd_idle_tx: got %b want 1", Tx_out); end
  endtask

  task automatic test_parity_even;
    logic [127:0] line;
    int unsigned  n;
    Par_EN = 1'b1; Par_TYP = 1'b0; Stop_Two = 1'b0; Prescale = 16'd1;
    write_word(8'hDA);
    capture(line, n);
    checks++; if (n != 11) begin errors++; $display("FAIL even_busy_len: got %0d want 11", n); end
    checks++; if (line[9] !== 1'b1) begin errors++; $display("FAIL even_parity_bit: got %b want 1", line[9]); end
    checks++; if (line[10:0] !== 11'b11110110100) begin
      errors++; $display("FAIL even_frame: got %b want %b", line[10:0], 11'b11110110100);
    end
  endtask

  task automatic test_two_stop_prescale;
    logic [127:0] line;
    int unsigned  n;
    logic [10:0]  expb;
    logic         ok;
    expb = 11'b11101001010;
    Par_EN = 1'b0; Par_TYP = 1'b0; Stop_Two = 1'b1; Prescale = 16'd4;
    write_word(8'hA5);
    fork
      capture(line, n);
      begin
        #100;
        Prescale = 16'd2; Par_EN = 1'b1; Stop_Two = 1'b0;
      end
    join
    checks++; if (n != 44) begin errors++; $display("FAIL stop2_len: got %0d want 44", n); end
    for (int unsigned b = 0; b < 11; b++) begin
      ok = 1'b1;
      for (int unsigned k = 0; k < 4; k++) if (line[4*b+k] !== expb[b]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL stop2_bit%0d: got %b want %b%b%b%b", b, line[4*b+:4], expb[b], expb[b], expb[b], expb[b]);
      end
    end
  endtask

  task automatic test_prescale_zero;
    logic [127:0] line;
    int unsigned  n;
    Par_EN = 1'b0; Par_TYP = 1'b0; Stop_Two = 1'b0; Prescale = 16'd0;
    write_word(8'h00);
    capture(line, n);
    checks++; if (n != 10) begin errors++; $display("FAIL presc0_len: got %0d want 10", n); end
    checks++; if (line[9:0] !== 10'b1000000000) begin
      errors++; $display("FAIL presc0_frame: got %b want %b", line[9:0], 10'b1000000000);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] line, expl;
    logic [7:0]   fs, ov, d;
    int unsigned  n;
    Par_EN = 1'b0; Par_TYP = 1'b0; Stop_Two = 1'b0; Prescale = 16'd1;
    expl = '1;
    for (int unsigned f = 0; f < 5; f++) begin
      d = 8'(f + 1);
      expl[10*f] = 1'b0;
      for (int unsigned b = 0; b < 8; b++) expl[10*f+1+b] = d[b];
      expl[10*f+9] = 1'b1;
    end
    fork
      write_burst(5, fs, ov);
      capture(line, n);
    join
    checks++; if (n != 50) begin errors++; $display("FAIL b2b_busy_len: got %0d want 50", n); end
    checks++; if (line[49:0] !== expl[49:0]) begin
      errors++; $display("FAIL b2b_line: got %h want %h", line[49:0], expl[49:0]);
    end
    checks++; if (ov[4:0] !== 5'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 00000", ov[4:0]); end
  endtask

  task automatic test_overflow;
    logic [127:0] line, expl;
    logic [7:0]   fs, ov, d;
    logic         ov_after, late_busy;
    int unsigned  n;
    Par_EN = 1'b0; Par_TYP = 1'b0; Stop_Two = 1'b0; Prescale = 16'd1;
    expl = '1;
    for (int unsigned f = 0; f < 5; f++) begin
      d = 8'(f + 1);
      expl[10*f] = 1'b0;
      for (int unsigned b = 0; b < 8; b++) expl[10*f+1+b] = d[b];
      expl[10*f+9] = 1'b1;
    end
    ov_after = 1'b1;
    fork
      begin
        write_burst(6, fs, ov);
        @(posedge clk); #1;
        ov_after = overflow;
      end
      capture(line, n);
    join
    checks++; if (fs[3] !== 1'b0) begin errors++; $display("FAIL ovf_full_early: got %b want 0", fs[3]); end
    checks++; if (fs[4] !== 1'b1) begin errors++; $display("FAIL ovf_full_4th: got %b want 1", fs[4]); end
    checks++; if (ov[5:0] !== 6'b100000) begin errors++; $display("FAIL ovf_pulse: got %b want 100000", ov[5:0]); end
    checks++; if (ov_after !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", ov_after); end
    checks++; if (n != 50) begin errors++; $display("FAIL ovf_busy_len: got %0d want 50", n); end
    checks++; if (line[49:0] !== expl[49:0]) begin
      errors++; $display("FAIL ovf_line: got %h want %h", line[49:0], expl[49:0]);
    end
    late_busy = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy) late_busy = 1'b1;
    end
    checks++; if (late_busy !== 1'b0) begin errors++; $display("FAIL ovf_extra_frame: got busy=%b want 0", late_busy); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0]  fs, ov;
    int unsigned w;
    logic        bad;
    Par_EN = 1'b0; Par_TYP = 1'b0; Stop_Two = 1'b0; Prescale = 16'd4;
    write_burst(2, fs, ov);
    w = 0;
    while (!busy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (10) @(posedge clk);
    #3;
    checks++; if (Tx_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got tx=%b busy=%b want tx=0 busy=1", Tx_out, busy);
    end
    rst = 1'b0;
    #1;
    checks++; if (Tx_out !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", Tx_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || Tx_out !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_no_frames: got activity=%b want 0", bad); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b want 0", fifo_full); end
  endtask

  initial begin
    test_reset;
    test_parity_odd;
    test_parity_even;
    test_two_stop_prescale;
    test_prescale_zero;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
